filter_seq: RTL and testbench



---
 rtl/filter_seq_if.sv | 31 +++
 rtl/filter_seq.sv | 150 +++++++++++++++
 tb/tb_filter_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_seq_if.sv
// rtl/filter_seq_if.sv - coefficient, sample, result and filter-side signals of filter_seq
interface filter_seq_if;
    logic [9:0]  cf_data;
    logic        cf_valid;
    logic        cf_ready;
    logic [15:0] smp_in;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic [9:0]  flt_coef;
    logic        flt_coef_load;
    logic [15:0] flt_sig_in;
    logic        flt_start;
    logic [15:0] flt_sig_out;
    logic        flt_done;

    // Environment side: decoder, source generator, result sink and the filter itself.
    modport master (
        output cf_data, cf_valid, smp_in, smp_valid, flt_sig_out, flt_done,
        input  cf_ready, smp_ready, out_data, out_valid,
        input  flt_coef, flt_coef_load, flt_sig_in, flt_start
    );

    // Sequencer side.
    modport slave (
        input  cf_data, cf_valid, smp_in, smp_valid, flt_sig_out, flt_done,
        output cf_ready, smp_ready, out_data, out_valid,
        output flt_coef, flt_coef_load, flt_sig_in, flt_start
    );
endinterface

// File: rtl/filter_seq.sv
// rtl/filter_seq.sv - coefficient-load and start/done sequencer for the 12th-order all-pole filter
module filter_seq (
    input  logic         clk,
    input  logic         rst_an,
    filter_seq_if.slave  bus
);
    localparam int NCOEF = 12;

    typedef enum logic [2:0] {IDLE, LOAD, GUARD, BUSY, OUT} state_t;

    state_t      state_q, state_d;
    logic [9:0]  bank_q [NCOEF];
    logic [9:0]  bank_d [NCOEF];
    logic [3:0]  wptr_q, wptr_d;
    logic        bank_full_q, bank_full_d;
    logic [3:0]  rd_q, rd_d;
    logic        gcnt_q, gcnt_d;
    logic [9:0]  flt_coef_q, flt_coef_d;
    logic        flt_coef_load_q, flt_coef_load_d;
    logic [15:0] flt_sig_in_q, flt_sig_in_d;
    logic        flt_start_q, flt_start_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        cf_fire, smp_fire, smp_ready;

    // smp_ready is gated by rst_an so it reads 0 while reset is held, even with the filter idle.
    assign smp_ready         = rst_an && (state_q == IDLE) && !bank_full_q && bus.flt_done;
    assign smp_fire          = smp_ready && bus.smp_valid;
    assign cf_fire           = bus.cf_valid && !bank_full_q;

    assign bus.cf_ready      = !bank_full_q;
    assign bus.smp_ready     = smp_ready;
    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.flt_coef      = flt_coef_q;
    assign bus.flt_coef_load = flt_coef_load_q;
    assign bus.flt_sig_in    = flt_sig_in_q;
    assign bus.flt_start     = flt_start_q;

    // Bank fill from the decoder; the 12th write marks the frame full, the last load frees it.
    always_comb begin
        bank_d      = bank_q;
        wptr_d      = wptr_q;
        bank_full_d = bank_full_q;
        if (cf_fire) begin
            bank_d[wptr_q] = bus.cf_data;
            if (wptr_q == 4'd11) begin
                wptr_d      = 4'd0;
                bank_full_d = 1'b1;
            end else begin
                wptr_d = wptr_q + 4'd1;
            end
        end
        if ((state_q == LOAD) && (rd_q == 4'd11)) begin
            bank_full_d = 1'b0;
        end
    end

    // Sequencer: a full bank is loaded before any sample, and a run is guarded against stale done.
    always_comb begin
        state_d         = state_q;
        rd_d            = rd_q;
        gcnt_d          = gcnt_q;
        flt_coef_d      = flt_coef_q;
        flt_coef_load_d = 1'b0;
        flt_sig_in_d    = flt_sig_in_q;
        flt_start_d     = 1'b0;
        out_data_d      = out_data_q;
        out_valid_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bank_full_q && bus.flt_done) begin
                    // Present bank[0] in the first LOAD cycle so coef_load lines up with LOAD.
                    state_d         = LOAD;
                    rd_d            = 4'd0;
                    flt_coef_load_d = 1'b1;
                    flt_coef_d      = bank_q[0];
                end else if (smp_fire) begin
                    flt_sig_in_d = bus.smp_in;
                    flt_start_d  = 1'b1;
                    gcnt_d       = 1'b0;
                    state_d      = GUARD;
                end
            end
            LOAD: begin
                if (rd_q == 4'd11) begin
                    state_d = IDLE;
                end else begin
                    rd_d            = rd_q + 4'd1;
                    flt_coef_load_d = 1'b1;
                    flt_coef_d      = bank_q[rd_q + 4'd1];
                end
            end
            GUARD: begin
                // The filter still shows done for one cycle after it samples start.
                if (gcnt_q) begin
                    state_d = BUSY;
                end else begin
                    gcnt_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.flt_done) begin
                    out_data_d  = bus.flt_sig_out;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partially written frame.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q         <= IDLE;
            for (int i = 0; i < NCOEF; i++) begin
                bank_q[i] <= 10'd0;
            end
            wptr_q          <= 4'd0;
            bank_full_q     <= 1'b0;
            rd_q            <= 4'd0;
            gcnt_q          <= 1'b0;
            flt_coef_q      <= 10'd0;
            flt_coef_load_q <= 1'b0;
            flt_sig_in_q    <= 16'd0;
            flt_start_q     <= 1'b0;
            out_data_q      <= 16'd0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            bank_q          <= bank_d;
            wptr_q          <= wptr_d;
            bank_full_q     <= bank_full_d;
            rd_q            <= rd_d;
            gcnt_q          <= gcnt_d;
            flt_coef_q      <= flt_coef_d;
            flt_coef_load_q <= flt_coef_load_d;
            flt_sig_in_q    <= flt_sig_in_d;
            flt_start_q     <= flt_start_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_filter_seq.sv
// tb/tb_filter_seq.sv - directed self-checking bench for filter_seq with a stub filter
module tb_filter_seq;
    logic clk = 1'b0;
    logic rst_an = 1'b0;
    always #5 clk = ~clk;

    filter_seq_if bus ();

    filter_seq dut (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0]  coefq [$];
    int          coef_cyc [$];
    logic [15:0] outq [$];
    int          out_cyc [$];
    int          start_cyc [$];
    int          start_busy = 0;
    int          load_start = 0;
    int          load_busy  = 0;
    int          sig_bad    = 0;
    logic [15:0] held = 16'd0;

    // Stub filter: done stays high one cycle after start is sampled, drops for the run,
    // reads sig_in mid-run and returns it (zero-coefficient pass-through); garbage while busy.
    logic        f_done;
    logic [15:0] f_out, f_mid;
    int          f_cnt;
    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            f_done <= 1'b1;
            f_out  <= 16'd0;
            f_mid  <= 16'd0;
            f_cnt  <= 0;
        end else if (f_cnt != 0) begin
            f_cnt <= f_cnt - 1;
            if (f_cnt == 8) f_done <= 1'b0;
            if (f_cnt == 4) f_mid <= bus.flt_sig_in;
            if (f_cnt == 1) begin
                f_done <= 1'b1;
                f_out  <= f_mid;
            end
        end else if (bus.flt_start) begin
            f_cnt <= 8;
            f_out <= 16'hBAD0;
        end
    end
    assign bus.flt_done    = f_done;
    assign bus.flt_sig_out = f_out;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: records loads, results, starts and protocol violations.
    always @(negedge clk) begin
        if (rst_an) begin
            if (bus.flt_coef_load) begin
                coefq.push_back(bus.flt_coef);
                coef_cyc.push_back(cyc);
                if (f_cnt != 0 || !f_done) load_busy++;
                if (bus.flt_start) load_start++;
            end
            if (bus.out_valid) begin
                outq.push_back(bus.out_data);
                out_cyc.push_back(cyc);
            end
            if (bus.flt_start) begin
                start_cyc.push_back(cyc);
                held = bus.flt_sig_in;
                if (f_cnt != 0) start_busy++;
            end
            if (f_cnt != 0 && bus.flt_sig_in !== held) sig_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_q();
        coefq.delete();
        coef_cyc.delete();
        outq.delete();
        out_cyc.delete();
        start_cyc.delete();
    endtask

    task automatic chk_reset(input string pfx);
        check({pfx, "_cf_ready"},      {31'd0, bus.cf_ready},      32'd1);
        check({pfx, "_smp_ready"},     {31'd0, bus.smp_ready},     32'd0);
        check({pfx, "_out_data"},      {16'd0, bus.out_data},      32'd0);
        check({pfx, "_out_valid"},     {31'd0, bus.out_valid},     32'd0);
        check({pfx, "_flt_coef"},      {22'd0, bus.flt_coef},      32'd0);
        check({pfx, "_flt_coef_load"}, {31'd0, bus.flt_coef_load}, 32'd0);
        check({pfx, "_flt_sig_in"},    {16'd0, bus.flt_sig_in},    32'd0);
        check({pfx, "_flt_start"},     {31'd0, bus.flt_start},     32'd0);
    endtask

    task automatic write_cf(input logic [9:0] v);
        int to = 0;
        bus.cf_data  = v;
        bus.cf_valid = 1'b1;
        while (!bus.cf_ready && to < 200) begin
            step();
            to++;
        end
        if (to >= 200) check("cf_wait_timeout", 32'd0, 32'd1);
        step();
        bus.cf_valid = 1'b0;
    endtask

    task automatic write_frame(input logic [9:0] base, input int n);
        for (int i = 0; i < n; i++) write_cf(base + 10'(i));
    endtask

    // Leaves smp_valid high; the caller drops it or changes the sample.
    task automatic hs(input logic [15:0] v, output int c);
        int to = 0;
        bus.smp_in    = v;
        bus.smp_valid = 1'b1;
        while (!bus.smp_ready && to < 300) begin
            step();
            to++;
        end
        if (to >= 300) check("smp_wait_timeout", 32'd0, 32'd1);
        step();
        c = cyc;
    endtask

    task automatic wait_outs(input int n);
        int to = 0;
        while (outq.size() < n && to < 300) begin
            step();
            to++;
        end
        if (to >= 300) check("out_wait_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] oq(input int i);
        return (outq.size() > i) ? {16'd0, outq[i]} : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] cq(input int i);
        return (coefq.size() > i) ? {22'd0, coefq[i]} : 32'hFFFF_FFFF;
    endfunction
    function automatic int ccyc(input int i);
        return (coef_cyc.size() > i) ? coef_cyc[i] : -1000;
    endfunction
    function automatic int ocyc(input int i);
        return (out_cyc.size() > i) ? out_cyc[i] : -1000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, c1, c2, to;
        bus.cf_data   = 10'd0;
        bus.cf_valid  = 1'b0;
        bus.smp_in    = 16'd0;
        bus.smp_valid = 1'b0;
        #12;
        chk_reset("rst0");
        step();
        rst_an = 1'b1;
        step();
        clear_q();

        // Frame 0x001..0x00C, loaded in order over 12 consecutive cycles.
        write_frame(10'h001, 12);
        wait_cycles(20);
        check("t1_load_count", coefq.size(), 32'd12);
        for (int i = 0; i < 12; i++) check($sformatf("t1_coef%0d", i), cq(i), 32'(i + 1));
        check("t1_load_span", ccyc(11) - ccyc(0), 32'd11);
        check("t1_cf_ready", {31'd0, bus.cf_ready}, 32'd1);
        clear_q();

        // Zero frame, then a single sample: one start, held sig_in, one result.
        write_frame(10'h000, 12);
        wait_cycles(16);
        clear_q();
        hs(16'h1234, c);
        bus.smp_valid = 1'b0;
        wait_outs(1);
        wait_cycles(3);
        check("t2_out_data", oq(0), 32'h1234);
        check("t2_out_count", outq.size(), 32'd1);
        check("t2_start_count", start_cyc.size(), 32'd1);
        check("t2_start_cycle", (start_cyc.size() > 0) ? start_cyc[0] - c : -1, 32'd0);
        check("t2_out_latency", ocyc(0) - c, 32'd10);
        check("t2_sig_in", {16'd0, bus.flt_sig_in}, 32'h1234);
        clear_q();

        // Back-to-back samples with smp_valid held.
        hs(16'h0100, c1);
        hs(16'h0200, c2);
        bus.smp_valid = 1'b0;
        wait_outs(2);
        check("t3_out0", oq(0), 32'h0100);
        check("t3_out1", oq(1), 32'h0200);
        check("t3_hs_gap", c2 - c1, 32'd12);
        check("t3_start_count", start_cyc.size(), 32'd2);
        clear_q();

        // Frame completes while a run is busy: run finishes, then LOAD, then the next sample.
        write_frame(10'h020, 11);
        hs(16'h0300, c1);
        bus.smp_valid = 1'b0;
        write_cf(10'h02B);
        hs(16'h0400, c2);
        bus.smp_valid = 1'b0;
        wait_outs(2);
        check("t4_out0", oq(0), 32'h0300);
        check("t4_out1", oq(1), 32'h0400);
        check("t4_load_count", coefq.size(), 32'd12);
        check("t4_coef0", cq(0), 32'h020);
        check("t4_coef11", cq(11), 32'h02B);
        check("t4_load_after_out", ccyc(0) - ocyc(0), 32'd2);
        check("t4_return_cycle", c2 - ccyc(11), 32'd2);
        clear_q();

        // Reset during BUSY with a partial frame written.
        hs(16'h0500, c);
        bus.smp_valid = 1'b0;
        write_frame(10'h070, 5);
        rst_an = 1'b0;
        #2;
        chk_reset("rst_busy");
        step();
        step();
        rst_an = 1'b1;
        step();
        clear_q();

        // Reset during LOAD at rd=5; the earlier partial frame must be gone.
        write_frame(10'h040, 12);
        to = 0;
        while (!(bus.flt_coef_load && bus.flt_coef == 10'h045) && to < 100) begin
            step();
            to++;
        end
        if (to >= 100) check("t5_load_wait_timeout", 32'd0, 32'd1);
        check("t5_first_coef", cq(0), 32'h040);
        check("t5_loads_before_rst", coefq.size(), 32'd5);
        rst_an = 1'b0;
        #2;
        chk_reset("rst_load");
        step();
        step();
        rst_an = 1'b1;
        step();
        clear_q();

        // Normal operation after reset: full frame then a sample.
        write_frame(10'h040, 12);
        wait_cycles(16);
        check("t6_load_count", coefq.size(), 32'd12);
        check("t6_coef0", cq(0), 32'h040);
        check("t6_coef5", cq(5), 32'h045);
        check("t6_coef11", cq(11), 32'h04B);
        hs(16'h0555, c);
        bus.smp_valid = 1'b0;
        wait_outs(1);
        check("t6_out", oq(0), 32'h0555);

        check("mon_start_while_busy", start_busy, 32'd0);
        check("mon_load_and_start", load_start, 32'd0);
        check("mon_load_while_busy", load_busy, 32'd0);
        check("mon_sig_in_hold", sig_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
